bkg_scroll_reader: RTL and testbench

BKG_SCROLL_READER -- requirements
Module: bkg_scroll_reader

---
 rtl/bkg_scroll_reader.sv | 153 +++++++++++++++
 tb/tb_bkg_scroll_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bkg_scroll_reader.sv
// -----------------------------------------------------------------------------
// bkg_scroll_reader
//    Reads a vertically scrollable background image out of an external
//    synchronous RAM and returns one RGB pixel per sampled pixel tick.
//
//    Ports
//       Clk, Reset          : system clock, synchronous active-high reset
//       pixel_en            : pixel tick; DrawX/DrawY/display_active sampled
//       DrawX, DrawY        : screen column (0..639) / row (0..479)
//       display_active      : 1 inside the visible area
//       frame_start         : one-Clk pulse at the start of vertical blank
//       scroll_valid/amt    : scroll request (texel rows) offered
//       scroll_ready        : request can be accepted (FSM in IDLE)
//       read_address        : background RAM read address (row*IMG_W + col)
//       ram_data            : RAM read data, valid one Clk after the address
//       Red, Green, Blue    : pixel colour, forced to 0 outside display
//       pix_valid           : RGB belongs to a sample taken 3 Clk earlier
// -----------------------------------------------------------------------------
module bkg_scroll_reader #(
   parameter int unsigned IMG_W = 160,
   parameter int unsigned IMG_H = 160
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        pixel_en,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        display_active,
   input  logic        frame_start,
   input  logic        scroll_valid,
   input  logic [7:0]  scroll_amt,
   output logic        scroll_ready,
   output logic [14:0] read_address,
   input  logic [23:0] ram_data,
   output logic [7:0]  Red,
   output logic [7:0]  Green,
   output logic [7:0]  Blue,
   output logic        pix_valid
);

   typedef enum logic {
      S_IDLE,
      S_PENDING
   } state_t;

   localparam logic [9:0]  H10    = 10'(IMG_H);
   localparam logic [7:0]  AMT_MX = 8'(IMG_H - 1);
   localparam logic [14:0] W15    = 15'(IMG_W);

   state_t      state_q, state_d;
   logic [7:0]  offset_q, offset_d;
   logic [7:0]  pending_q, pending_d;

   logic [14:0] addr_q, addr_d;
   logic        v1_q, act1_q, v2_q, act2_q, pv_q;
   logic [7:0]  red_q, green_q, blue_q;

   logic [9:0]  row_sum, row_s1, row_s2;
   logic [9:0]  off_sum;

   // Low address bits of DrawX and DrawY[0] select within a texel only.
   logic        unused_bits;
   assign unused_bits = ^{DrawX[1:0], DrawY[0]};

   // ---------------- scroll FSM ----------------
   always_comb begin
      state_d      = state_q;
      offset_d     = offset_q;
      pending_d    = pending_q;
      scroll_ready = (state_q == S_IDLE);
      off_sum      = {2'b00, offset_q} + H10 - {2'b00, pending_q};
      if (off_sum >= H10) begin
         off_sum = off_sum - H10;
      end
      unique case (state_q)
         S_IDLE: begin
            // A frame_start arriving together with the request is not used
            // to apply it; the request waits for the following frame_start.
            if (scroll_valid) begin
               pending_d = (scroll_amt > AMT_MX) ? AMT_MX : scroll_amt;
               state_d   = S_PENDING;
            end
         end
         S_PENDING: begin
            if (frame_start) begin
               offset_d = off_sum[7:0];
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         offset_q  <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         offset_q  <= offset_d;
         pending_q <= pending_d;
      end
   end

   // ---------------- address generation ----------------
   // Sum is at most 239+159 = 398, so two conditional subtractions of IMG_H
   // bring it into range without a divider.
   always_comb begin
      row_sum = {1'b0, DrawY[9:1]} + {2'b00, offset_q};
      row_s1  = (row_sum >= H10) ? (row_sum - H10) : row_sum;
      row_s2  = (row_s1  >= H10) ? (row_s1  - H10) : row_s1;
      addr_d  = 15'(row_s2) * W15 + {7'd0, DrawX[9:2]};
   end

   // ---------------- pixel pipeline ----------------
   // Stage 1: address registered; stage 2: RAM drives ram_data;
   // stage 3: colour registered alongside pix_valid.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         addr_q  <= '0;
         v1_q    <= 1'b0;
         act1_q  <= 1'b0;
         v2_q    <= 1'b0;
         act2_q  <= 1'b0;
         pv_q    <= 1'b0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else begin
         if (pixel_en) begin
            addr_q <= addr_d;
         end
         v1_q   <= pixel_en;
         act1_q <= pixel_en & display_active;
         v2_q   <= v1_q;
         act2_q <= act1_q;
         pv_q   <= v2_q;
         if (v2_q) begin
            red_q   <= act2_q ? ram_data[23:16] : '0;
            green_q <= act2_q ? ram_data[15:8]  : '0;
            blue_q  <= act2_q ? ram_data[7:0]   : '0;
         end
      end
   end

   assign read_address = addr_q;
   assign pix_valid    = pv_q;
   assign Red          = red_q;
   assign Green        = green_q;
   assign Blue         = blue_q;

endmodule

// File: tb/tb_bkg_scroll_reader.sv
// -----------------------------------------------------------------------------
// tb_bkg_scroll_reader
//    Directed scenarios plus a randomized run against a behavioural model of
//    the scroll offset, address mapping and 3-Clk colour pipeline. The RAM is
//    modelled as a synchronous memory whose contents are a hash of the address.
// -----------------------------------------------------------------------------
module tb_bkg_scroll_reader;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        pixel_en = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        display_active = 1'b0;
   logic        frame_start = 1'b0;
   logic        scroll_valid = 1'b0;
   logic [7:0]  scroll_amt = '0;
   logic        scroll_ready;
   logic [14:0] read_address;
   logic [23:0] ram_data = '0;
   logic [7:0]  Red, Green, Blue;
   logic        pix_valid;

   logic        force_en = 1'b0;
   logic [23:0] force_val = '0;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // model state
   int          m_off  = 0;
   int          m_pend = 0;
   bit          m_busy = 0;
   int          exp_addr = 0;

   typedef struct {
      bit          v;
      logic [23:0] rgb;
   } pix_t;
   pix_t pq[$];

   bkg_scroll_reader #(.IMG_W(160), .IMG_H(160)) dut (
      .Clk(Clk), .Reset(Reset), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
      .display_active(display_active), .frame_start(frame_start),
      .scroll_valid(scroll_valid), .scroll_amt(scroll_amt), .scroll_ready(scroll_ready),
      .read_address(read_address), .ram_data(ram_data),
      .Red(Red), .Green(Green), .Blue(Blue), .pix_valid(pix_valid)
   );

   always #5 Clk = ~Clk;

   function automatic logic [23:0] ram_f(input int a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E3779B1;
      return h[31:8];
   endfunction

   always @(posedge Clk) ram_data <= force_en ? force_val : ram_f(int'(read_address));

   function automatic int addr_of(input int x, input int y, input int off);
      return (((y / 2) + off) % 160) * 160 + (x / 4);
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic model_scroll(input bit sv, input int amt, input bit fs);
      if (!m_busy) begin
         if (sv) begin
            m_pend = (amt > 159) ? 159 : amt;
            m_busy = 1;
         end
      end else if (fs) begin
         m_off  = (m_off + 160 - m_pend) % 160;
         m_busy = 0;
      end
   endtask

   // one clock of stimulus; model advanced with the values sampled at the edge
   task automatic cycle(input bit pen, input int x, input int y, input bit act,
                        input bit sv, input int amt, input bit fs);
      pixel_en = pen; DrawX = 10'(x); DrawY = 10'(y); display_active = act;
      scroll_valid = sv; scroll_amt = 8'(amt); frame_start = fs;
      if (pen) exp_addr = addr_of(x, y, m_off);
      model_scroll(sv, amt, fs);
      tick();
      pixel_en = 0; scroll_valid = 0; frame_start = 0;
   endtask

   task automatic apply_reset();
      Reset = 1; tick(); tick();
      Reset = 0;
      m_off = 0; m_pend = 0; m_busy = 0; exp_addr = 0;
      pq.delete();
   endtask

   task automatic test_reset();
      Reset = 1; pixel_en = 1; scroll_valid = 1; frame_start = 1; scroll_amt = 8'd40;
      DrawX = 10'd300; DrawY = 10'd200; display_active = 1;
      tick(); tick();
      chk_cnt++; if (read_address !== 15'd0) $display("FAIL reset_addr got=%0d exp=0", read_address); else pass_cnt++;
      chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL reset_pv got=%0b exp=0", pix_valid); else pass_cnt++;
      chk_cnt++; if ({Red, Green, Blue} !== 24'd0) $display("FAIL reset_rgb got=%06h exp=000000", {Red, Green, Blue}); else pass_cnt++;
      chk_cnt++; if (scroll_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", scroll_ready); else pass_cnt++;
      Reset = 0; pixel_en = 0; scroll_valid = 0; frame_start = 0;
      tick();
      chk_cnt++; if (scroll_ready !== 1'b1) $display("FAIL post_reset_ready got=%0b exp=1", scroll_ready); else pass_cnt++;
      m_off = 0; m_busy = 0; exp_addr = 0;
   endtask

   task automatic test_first_pixel();
      force_en = 1; force_val = 24'hAABBCC;
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'd0) $display("FAIL first_addr got=%0d exp=0", read_address); else pass_cnt++;
      tick();
      chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL first_pv_early got=%0b exp=0", pix_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (pix_valid !== 1'b1) $display("FAIL first_pv got=%0b exp=1", pix_valid); else pass_cnt++;
      chk_cnt++; if ({Red, Green, Blue} !== 24'hAABBCC) $display("FAIL first_rgb got=%06h exp=AABBCC", {Red, Green, Blue}); else pass_cnt++;
      tick();
      chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL first_pv_pulse got=%0b exp=0", pix_valid); else pass_cnt++;
      force_en = 0;
   endtask

   task automatic test_corner();
      cycle(1, 639, 479, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'd12799) $display("FAIL corner_addr got=%0d exp=12799", read_address); else pass_cnt++;
      tick(); tick(); tick();
   endtask

   task automatic test_scroll();
      cycle(0, 0, 0, 0, 1, 10, 0);
      chk_cnt++; if (scroll_ready !== 1'b0) $display("FAIL scroll_busy got=%0b exp=0", scroll_ready); else pass_cnt++;
      cycle(0, 0, 0, 0, 1, 77, 0);  // ignored while pending
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk_cnt++; if (scroll_ready !== 1'b1) $display("FAIL scroll_ready_back got=%0b exp=1", scroll_ready); else pass_cnt++;
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'd24000) $display("FAIL scroll_addr got=%0d exp=24000", read_address); else pass_cnt++;
      tick(); tick(); tick();
   endtask

   task automatic test_same_cycle();
      apply_reset();
      cycle(0, 0, 0, 0, 1, 5, 1);
      chk_cnt++; if (scroll_ready !== 1'b0) $display("FAIL same_busy got=%0b exp=0", scroll_ready); else pass_cnt++;
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'd0) $display("FAIL same_unchanged got=%0d exp=0", read_address); else pass_cnt++;
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'd24800) $display("FAIL same_applied got=%0d exp=24800", read_address); else pass_cnt++;
      tick(); tick(); tick();
   endtask

   task automatic test_clamp_blank();
      apply_reset();
      cycle(0, 0, 0, 0, 1, 200, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'd160) $display("FAIL clamp_addr got=%0d exp=160", read_address); else pass_cnt++;
      // frame_start in IDLE leaves offset alone; boundary row wraps 239+1 -> 80
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(1, 639, 479, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'(exp_addr)) $display("FAIL idle_fs_addr got=%0d exp=%0d", read_address, exp_addr); else pass_cnt++;
      force_en = 1; force_val = 24'hFFFFFF;
      cycle(1, 100, 50, 0, 0, 0, 0);
      tick(); tick();
      chk_cnt++; if (pix_valid !== 1'b1) $display("FAIL blank_pv got=%0b exp=1", pix_valid); else pass_cnt++;
      chk_cnt++; if ({Red, Green, Blue} !== 24'd0) $display("FAIL blank_rgb got=%06h exp=000000", {Red, Green, Blue}); else pass_cnt++;
      force_en = 0;
      tick();
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      cycle(0, 0, 0, 0, 1, 10, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);          // offset 150
      cycle(0, 0, 0, 0, 1, 30, 0);         // pending
      cycle(1, 320, 240, 1, 0, 0, 0);      // pixel in flight
      Reset = 1; tick();
      chk_cnt++; if (scroll_ready !== 1'b1) $display("FAIL midrst_ready got=%0b exp=1", scroll_ready); else pass_cnt++;
      chk_cnt++; if (read_address !== 15'd0) $display("FAIL midrst_addr got=%0d exp=0", read_address); else pass_cnt++;
      Reset = 0;
      m_off = 0; m_pend = 0; m_busy = 0;
      for (int i = 0; i < 4; i++) begin
         chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL midrst_pv%0d got=%0b exp=0", i, pix_valid); else pass_cnt++;
         tick();
      end
      cycle(0, 0, 0, 0, 0, 0, 1);          // discarded request must not apply
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk_cnt++; if (read_address !== 15'd0) $display("FAIL midrst_offset got=%0d exp=0", read_address); else pass_cnt++;
      tick(); tick(); tick();
   endtask

   task automatic test_random();
      pix_t p, e;
      int x, y, amt;
      bit pen, act, sv, fs;
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         pen = ($urandom_range(1, 0) == 1);
         act = ($urandom_range(3, 0) != 0);
         sv  = ($urandom_range(7, 0) == 0);
         fs  = ($urandom_range(19, 0) == 0);
         x   = $urandom_range(639, 0);
         y   = (n % 50 == 0) ? 479 : $urandom_range(479, 0);
         amt = $urandom_range(255, 0);
         pixel_en = pen; DrawX = 10'(x); DrawY = 10'(y); display_active = act;
         scroll_valid = sv; scroll_amt = 8'(amt); frame_start = fs;
         if (pen) exp_addr = addr_of(x, y, m_off);
         p.v = pen;
         p.rgb = act ? ram_f(exp_addr) : 24'd0;
         pq.push_back(p);
         model_scroll(sv, amt, fs);
         tick();
         chk_cnt++; if (read_address !== 15'(exp_addr)) $display("FAIL rnd_addr n=%0d got=%0d exp=%0d", n, read_address, exp_addr); else pass_cnt++;
         chk_cnt++; if (scroll_ready !== !m_busy) $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, scroll_ready, !m_busy); else pass_cnt++;
         if (pq.size() == 3) begin
            e = pq.pop_front();
            chk_cnt++; if (pix_valid !== e.v) $display("FAIL rnd_pv n=%0d got=%0b exp=%0b", n, pix_valid, e.v); else pass_cnt++;
            if (e.v) begin
               chk_cnt++; if ({Red, Green, Blue} !== e.rgb) $display("FAIL rnd_rgb n=%0d got=%06h exp=%06h", n, {Red, Green, Blue}, e.rgb); else pass_cnt++;
            end
         end
      end
      pixel_en = 0; scroll_valid = 0; frame_start = 0;
      tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_first_pixel();
      test_corner();
      test_scroll();
      test_same_cycle();
      test_clamp_blank();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
